// File: rtl/three_eight_decoder_pulse.sv
// Registered 3-to-8 one-hot decoder with a valid/ready input handshake.
// Each enabled code drives its one-hot line for HOLD_CYCLES cycles, then
// the output goes to zero for GAP_CYCLES cycles before the next code can be
// accepted. Codes accepted with En=0 are dropped without leaving IDLE.
// Event_cnt counts enabled decodes and wraps from 255 to 0.
module three_eight_decoder_pulse #(
  parameter int HOLD_CYCLES = 4,  // 1..255
  parameter int GAP_CYCLES  = 1   // 0..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] In,
  input  logic       En,
  input  logic       In_valid,
  output logic       In_ready,
  output logic [7:0] Out,
  output logic       Out_valid,
  output logic [7:0] Event_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Counter reload values; the counter counts down to zero, so a phase of
  // N cycles is loaded with N-1. GAP_LOAD is unused when GAP_CYCLES is 0.
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] out_q, out_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] event_cnt_q, event_cnt_d;

  // Only IDLE can take a new code; decoded straight from the state.
  assign In_ready  = (state_q == IDLE);
  assign Out       = out_q;
  assign Out_valid = out_valid_q;
  assign Event_cnt = event_cnt_q;

  // State, counter and output registers; reset clears everything at once,
  // including any decode in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      out_q       <= 8'd0;
      out_valid_q <= 1'b0;
      event_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      event_cnt_q <= event_cnt_d;
    end
  end

  // Next-state and next-output logic; everything holds unless changed.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    event_cnt_d = event_cnt_q;
    unique case (state_q)
      IDLE: begin
        // A disabled code is consumed here but changes nothing, so
        // back-to-back disabled codes are taken every cycle.
        if (In_valid && En) begin
          out_d       = 8'd1 << In;
          out_valid_d = 1'b1;
          cnt_d       = HOLD_LOAD;
          event_cnt_d = event_cnt_q + 8'd1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == 8'd0) begin
          // Output drops to zero directly from one-hot; never two bits set.
          out_d       = 8'd0;
          out_valid_d = 1'b0;
          if (GAP_CYCLES > 0) begin
            cnt_d   = GAP_LOAD;
            state_d = GAP;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      GAP: begin
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_d       = 8'd0;
        out_valid_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_three_eight_decoder_pulse.sv
// Directed bench for three_eight_decoder_pulse: one instance with the
// default HOLD=4/GAP=1 timing and one with HOLD=1/GAP=0.
module tb_three_eight_decoder_pulse;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic [2:0] In = 3'd0;
  logic       En = 1'b0;
  logic       In_valid = 1'b0;
  logic       In_ready;
  logic [7:0] Out;
  logic       Out_valid;
  logic [7:0] Event_cnt;

  logic [2:0] In1 = 3'd0;
  logic       En1 = 1'b0;
  logic       In_valid1 = 1'b0;
  logic       In_ready1;
  logic [7:0] Out1;
  logic       Out_valid1;
  logic [7:0] Event_cnt1;

  int checks = 0;
  int errors = 0;

  logic [7:0] onehot_tbl [8];

  always #5 clk = ~clk;

  three_eight_decoder_pulse #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) u_dut (
    .clk(clk), .rst(rst), .In(In), .En(En), .In_valid(In_valid),
    .In_ready(In_ready), .Out(Out), .Out_valid(Out_valid),
    .Event_cnt(Event_cnt)
  );

  three_eight_decoder_pulse #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) u_dut1 (
    .clk(clk), .rst(rst), .In(In1), .En(En1), .In_valid(In_valid1),
    .In_ready(In_ready1), .Out(Out1), .Out_valid(Out_valid1),
    .Event_cnt(Event_cnt1)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sampling and driving happen 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    onehot_tbl[0] = 8'h01; onehot_tbl[1] = 8'h02;
    onehot_tbl[2] = 8'h04; onehot_tbl[3] = 8'h08;
    onehot_tbl[4] = 8'h10; onehot_tbl[5] = 8'h20;
    onehot_tbl[6] = 8'h40; onehot_tbl[7] = 8'h80;

    // Reset state
    repeat (2) tick();
    check("rst_out", Out, 8'h00);
    check("rst_vld", Out_valid, 1'b0);
    check("rst_cnt", Event_cnt, 8'd0);
    rst = 1'b0;
    check("rst_ready", In_ready, 1'b1);

    // 1: single code 5, hold 4, gap 1
    In = 3'd5; En = 1'b1; In_valid = 1'b1;
    tick();
    In_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("t1_out_hold", Out, 8'h20);
      check("t1_vld_hold", Out_valid, 1'b1);
      check("t1_ready_hold", In_ready, 1'b0);
      tick();
    end
    check("t1_out_gap", Out, 8'h00);
    check("t1_vld_gap", Out_valid, 1'b0);
    check("t1_ready_gap", In_ready, 1'b0);
    tick();
    check("t1_ready_back", In_ready, 1'b1);
    check("t1_cnt", Event_cnt, 8'd1);

    // 2: sweep all codes with In_valid held high
    for (int c = 0; c < 8; c++) begin
      check("t2_ready", In_ready, 1'b1);
      In = 3'(c); En = 1'b1; In_valid = 1'b1;
      tick();
      check("t2_out", Out, 32'(onehot_tbl[c]));
      check("t2_vld", Out_valid, 1'b1);
      for (int k = 0; k < 5; k++) begin
        tick();
        check("t2_onehot", 32'($countones(Out) <= 1), 1);
        check("t2_vld_match", Out_valid, |Out);
      end
    end
    check("t2_cnt", Event_cnt, 8'd9);

    // 3: disabled code is dropped, enabled code right after is decoded
    In = 3'd2; En = 1'b0; In_valid = 1'b1;
    tick();
    check("t3_dis_out", Out, 8'h00);
    check("t3_dis_vld", Out_valid, 1'b0);
    check("t3_dis_ready", In_ready, 1'b1);
    check("t3_dis_cnt", Event_cnt, 8'd9);
    In = 3'd6; En = 1'b1;
    tick();
    check("t3_en_out", Out, 8'h40);
    check("t3_en_cnt", Event_cnt, 8'd10);
    In_valid = 1'b0;
    repeat (5) tick();

    // 4: asynchronous reset mid-hold, In_valid high across reset release
    In = 3'd7; En = 1'b1; In_valid = 1'b1;
    tick();
    In_valid = 1'b0;
    tick();
    check("t4_out_pre", Out, 8'h80);
    #2 rst = 1'b1;
    #1;
    check("t4_async_out", Out, 8'h00);
    check("t4_async_vld", Out_valid, 1'b0);
    check("t4_async_cnt", Event_cnt, 8'd0);
    In = 3'd1; En = 1'b1; In_valid = 1'b1;
    tick();
    check("t4_in_rst_out", Out, 8'h00);
    rst = 1'b0;
    check("t4_ready", In_ready, 1'b1);
    tick();
    check("t4_first_out", Out, 8'h02);
    check("t4_first_cnt", Event_cnt, 8'd1);
    In_valid = 1'b0;
    repeat (5) tick();

    // 6: input changes during hold are ignored until In_ready returns
    In = 3'd3; En = 1'b1; In_valid = 1'b1;
    tick();
    check("t6_out", Out, 8'h08);
    check("t6_cnt", Event_cnt, 8'd2);
    In = 3'd4;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t6_out_held", Out, 8'h08);
    end
    tick();
    check("t6_gap_out", Out, 8'h00);
    check("t6_gap_ready", In_ready, 1'b0);
    tick();
    check("t6_idle_out", Out, 8'h00);
    check("t6_idle_ready", In_ready, 1'b1);
    tick();
    check("t6_next_out", Out, 8'h10);
    check("t6_next_cnt", Event_cnt, 8'd3);
    In_valid = 1'b0;
    repeat (5) tick();

    // 5a: Event_cnt wrap 255 -> 0
    In = 3'd6; En = 1'b1; In_valid = 1'b1;
    repeat (252 * 6) tick();
    check("t5_cnt_255", Event_cnt, 8'd255);
    check("t5_ready", In_ready, 1'b1);
    tick();
    check("t5_cnt_wrap", Event_cnt, 8'd0);
    check("t5_wrap_out", Out, 8'h40);
    In_valid = 1'b0;
    repeat (5) tick();

    // 5b: HOLD=1, GAP=0 instance accepts every second cycle
    check("t5b_ready0", In_ready1, 1'b1);
    In1 = 3'd3; En1 = 1'b1; In_valid1 = 1'b1;
    tick();
    check("t5b_out_a", Out1, 8'h08);
    check("t5b_vld_a", Out_valid1, 1'b1);
    check("t5b_ready_a", In_ready1, 1'b0);
    In1 = 3'd4;
    tick();
    check("t5b_out_idle", Out1, 8'h00);
    check("t5b_vld_idle", Out_valid1, 1'b0);
    check("t5b_ready_idle", In_ready1, 1'b1);
    tick();
    check("t5b_out_b", Out1, 8'h10);
    In_valid1 = 1'b0;
    tick();
    check("t5b_out_end", Out1, 8'h00);
    check("t5b_cnt", Event_cnt1, 8'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/three_eight_decoder_pulse.md
Name: three_eight_decoder_pulse

Overview:
- Registered 3-to-8 one-hot decoder with enable, for the output side of the 8-to-3 encoder path.
- Accepts a 3-bit code through a valid/ready handshake and drives the matching one-hot line for a programmable hold time.
- After the hold, drives a programmable all-zero gap before it accepts the next code.
- Keeps a wrapping count of decoded events for debug and scoreboard checks.

Parameters:
HOLD_CYCLES, 4, cycles the one-hot line stays asserted per decoded code; legal range 1..255
GAP_CYCLES, 1, all-zero cycles after each hold before the next accept; legal range 0..255

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  asynchronous, active-high reset
In  input  3  binary code to decode (0..7)
En  input  1  decode enable, sampled with In on accept
In_valid  input  1  In/En are valid this cycle
In_ready  output  1  block can accept a code this cycle
Out  output  8  registered one-hot decoded line, 0 when idle or in gap
Out_valid  output  1  high exactly while Out is driving a one-hot value
Event_cnt  output  8  number of enabled decodes, wraps 255 -> 0

Behaviour:
- Reset (rst=1, asynchronous, takes effect immediately without a clock edge):
  - state = IDLE; Out = 8'h00; Out_valid = 0; Event_cnt = 0; internal counter = 0.
  - In_ready = 1 once rst deasserts.
- In_ready is decoded combinationally from state: it is 1 only in IDLE.
- Accept occurs at a rising edge where In_valid=1 and In_ready=1. In and En are latched at that edge.
- States:
  - IDLE:
    - On accept with En=1: Out <= 1 << In; Out_valid <= 1; counter <= HOLD_CYCLES-1; Event_cnt <= Event_cnt+1 (mod 256); go to HOLD.
    - On accept with En=0: the code is consumed and dropped. Out stays 0, Out_valid stays 0, Event_cnt is unchanged, state stays IDLE, and In_ready stays 1, so back-to-back disabled codes are accepted every cycle.
    - With no accept: hold all values.
  - HOLD:
    - Out and Out_valid hold their values. The counter decrements each cycle.
    - When the counter = 0:
      - If GAP_CYCLES > 0: Out <= 0, Out_valid <= 0, counter <= GAP_CYCLES-1, go to GAP.
      - If GAP_CYCLES = 0: Out <= 0, Out_valid <= 0, go to IDLE.
  - GAP:
    - Out = 0. The counter decrements each cycle.
    - When the counter = 0, go to IDLE.
- Timing:
  - Latency: Out is visible in the cycle immediately after the accepting edge.
  - Out stays one-hot for exactly HOLD_CYCLES cycles.
  - In_ready is low for HOLD_CYCLES+GAP_CYCLES cycles.
  - Maximum enabled throughput is one code per HOLD_CYCLES+GAP_CYCLES+1 cycles. The extra cycle is the IDLE cycle in which the next accept occurs.
- Invariants:
  - Out has exactly one bit set whenever Out_valid=1, and Out = 0 whenever Out_valid=0.
  - Out never shows two bits set, including at transitions.
- Boundary conditions:
  - In_valid asserted while In_ready=0: ignored. The source must hold In_valid; nothing is queued.
  - Changes on In or En during HOLD/GAP have no effect on Out.
  - HOLD_CYCLES=1: Out is one-hot for a single cycle.
  - Event_cnt at 255 plus an enabled decode gives 0; there is no saturation flag.
  - rst asserted mid-HOLD or mid-GAP: Out and Out_valid clear at once. The in-flight code is lost, and Event_cnt clears, including the in-flight increment.
  - rst deasserting while In_valid=1: the first accept is at the first rising edge with rst=0.

Test Plan:
1. Reset, then HOLD=4, GAP=1, In=3'd5, En=1, In_valid for one accept -> Out=8'b00100000 and Out_valid=1 for 4 cycles; then Out=0 for 1 gap cycle; In_ready=0 for 5 cycles, then 1; Event_cnt=1.
2. Sweep In=0..7, En=1, In_valid held high -> Out walks 01,02,04,…,80, one code every 6 cycles; Event_cnt=8; never more than one bit of Out set.
3. In=3'd2 with En=0, then In=3'd6 with En=1 on consecutive cycles -> first is consumed with Out=0 and Event_cnt unchanged; second gives Out=8'b01000000 on the next cycle.
4. Assert rst two cycles into the hold of In=3'd7 -> Out=0, Out_valid=0 and Event_cnt=0 with no clock edge needed; after release, In_ready=1 and a new accept of In=3'd1 gives Out=8'h02.
5. 256 enabled decodes -> Event_cnt wraps to 0. Separately, with HOLD=1, GAP=0, back-to-back codes -> Out one-hot for 1 cycle, then 0 for the 1 IDLE cycle, accepting every 2nd cycle.
6. In_valid=1 with In changing from 3 to 4 during HOLD of code 3 -> Out stays 8'h08; code 4 is accepted only when In_ready returns to 1.
